// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared MIPS decode constants and record types. Holds the
//                opcode map, the immediate-extension encodings and the
//                packed records passed between decode and the ID/EX stage.
//  Revision    : 1.0  initial release
// ============================================================================
package mips_pkg;

    // Primary opcodes, instr[31:26]
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // Immediate extension unit control: bit1 = lui placement, bit0 = signed.
    // 2'b11 is reserved and never produced.
    localparam logic [1:0] EXT_ZERO = 2'b00;
    localparam logic [1:0] EXT_SIGN = 2'b01;
    localparam logic [1:0] EXT_LUI  = 2'b10;

    // Output of the combinational decoder for the IF/ID instruction word.
    typedef struct packed {
        logic        known;        // opcode is one the pipeline implements
        logic [1:0]  ext_type;
        logic        alu_src_imm;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        uses_rt;      // rt is a source operand (R-type, sw, beq, bne)
        logic [4:0]  dest_reg;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [15:0] imm;
    } dec_t;

    // Contents of the ID/EX pipeline register. All-zero is the bubble.
    typedef struct packed {
        logic        valid;
        logic        alu_src_imm;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        illegal;
        logic [4:0]  dest_reg;
        logic [1:0]  ext_type;
        logic [15:0] imm;
    } idex_t;

    // Opcode field of an instruction word.
    function automatic logic [5:0] opcode_of(input logic [31:0] word);
        return word[31:26];
    endfunction

endpackage : mips_pkg
`default_nettype wire

// File: rtl/id_decode.sv
`default_nettype none
// ============================================================================
//  Module      : id_decode
//  Description : Purely combinational decode of the IF/ID instruction word
//                into ID/EX control fields, register indices and immediate.
//  Revision    : 1.0  initial release
// ============================================================================
module id_decode
    import mips_pkg::*;
(
    input  logic [31:0] instr,
    output dec_t        ctrl
);

    logic [5:0] opcode;
    logic [4:0] rt_field;
    logic [4:0] rd_field;

    assign opcode   = opcode_of(instr);
    assign rt_field = instr[20:16];
    assign rd_field = instr[15:11];

    // Opcode table: control bits, extension mode and destination selection
    always_comb begin
        ctrl      = '0;
        ctrl.rs   = instr[25:21];
        ctrl.rt   = rt_field;
        ctrl.imm  = instr[15:0];
        unique case (opcode)
            OP_RTYPE: begin
                ctrl.known     = 1'b1;
                ctrl.ext_type  = EXT_ZERO;
                ctrl.reg_write = 1'b1;
                ctrl.uses_rt   = 1'b1;
                ctrl.dest_reg  = rd_field;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
                ctrl.known       = 1'b1;
                ctrl.ext_type    = EXT_SIGN;
                ctrl.alu_src_imm = 1'b1;
                ctrl.reg_write   = 1'b1;
                ctrl.dest_reg    = rt_field;
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                ctrl.known       = 1'b1;
                ctrl.ext_type    = EXT_ZERO;
                ctrl.alu_src_imm = 1'b1;
                ctrl.reg_write   = 1'b1;
                ctrl.dest_reg    = rt_field;
            end
            OP_LUI: begin
                ctrl.known       = 1'b1;
                ctrl.ext_type    = EXT_LUI;
                ctrl.alu_src_imm = 1'b1;
                ctrl.reg_write   = 1'b1;
                ctrl.dest_reg    = rt_field;
            end
            OP_LW: begin
                ctrl.known       = 1'b1;
                ctrl.ext_type    = EXT_SIGN;
                ctrl.alu_src_imm = 1'b1;
                ctrl.reg_write   = 1'b1;
                ctrl.mem_read    = 1'b1;
                ctrl.dest_reg    = rt_field;
            end
            OP_SW: begin
                // Store: immediate address offset, rt is the data source
                ctrl.known       = 1'b1;
                ctrl.ext_type    = EXT_SIGN;
                ctrl.alu_src_imm = 1'b1;
                ctrl.mem_write   = 1'b1;
                ctrl.uses_rt     = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                // Branches compare rs against rt in the ALU; the sign-extended
                // offset goes to the branch adder, not the ALU operand mux.
                ctrl.known    = 1'b1;
                ctrl.ext_type = EXT_SIGN;
                ctrl.uses_rt  = 1'b1;
            end
            default: begin
                ctrl.known = 1'b0;
            end
        endcase
    end

endmodule : id_decode
`default_nettype wire

// File: rtl/id_control.sv
`default_nettype none
// ============================================================================
//  Module      : id_control
//  Description : Instruction-decode stage control. Detects load-use hazards,
//                arbitrates flush / downstream stall / hazard / normal load,
//                owns the ID/EX pipeline register and a saturating count of
//                front-end stall cycles.
//  Revision    : 1.0  initial release
// ============================================================================
module id_control
    import mips_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    input  logic [31:0]      instr,
    input  logic             ex_stall,
    input  logic             flush,
    output logic [1:0]       extension_type,
    output logic             stall_if,
    output logic             valid_q,
    output logic             alu_src_imm_q,
    output logic             reg_write_q,
    output logic             mem_read_q,
    output logic             mem_write_q,
    output logic [4:0]       dest_reg_q,
    output logic [1:0]       ext_type_q,
    output logic [15:0]      imm_q,
    output logic             illegal_q,
    output logic [CNT_W-1:0] stall_cycles
);

    dec_t             dec;
    idex_t            idex_q;
    idex_t            idex_next;
    logic             idex_hold;
    logic             load_use;
    logic [CNT_W-1:0] stall_cnt_q;

    id_decode u_decode (
        .instr (instr),
        .ctrl  (dec)
    );

    // A load currently in ID/EX produces its data too late for an instruction
    // in ID that reads the loaded register. $zero is never a real dependency,
    // and unknown opcodes read nothing, so neither can cause a stall.
    assign load_use = instr_valid
                    & idex_q.valid
                    & idex_q.mem_read
                    & (idex_q.dest_reg != 5'd0)
                    & dec.known
                    & ((dec.rs == idex_q.dest_reg)
                       | ((dec.rt == idex_q.dest_reg) & dec.uses_rt));

    // Flush wins over both stall sources; reset forces the front end to run.
    assign stall_if       = rst_n & ~flush & (ex_stall | load_use);
    assign extension_type = dec.ext_type;

    // Next ID/EX contents: bubble unless a valid, known instruction can advance
    always_comb begin
        idex_next = '0;
        idex_hold = 1'b0;
        if (flush) begin
            idex_next = '0;
        end else if (ex_stall) begin
            idex_hold = 1'b1;
        end else if (load_use || !instr_valid) begin
            idex_next = '0;
        end else if (!dec.known) begin
            idex_next.illegal = 1'b1;
        end else begin
            idex_next.valid       = 1'b1;
            idex_next.alu_src_imm = dec.alu_src_imm;
            idex_next.reg_write   = dec.reg_write;
            idex_next.mem_read    = dec.mem_read;
            idex_next.mem_write   = dec.mem_write;
            idex_next.dest_reg    = dec.dest_reg;
            idex_next.ext_type    = dec.ext_type;
            idex_next.imm         = dec.imm;
        end
    end

    // ID/EX pipeline register, held while the downstream stage is stalled
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idex_q <= '0;
        end else if (!idex_hold) begin
            idex_q <= idex_next;
        end
    end

    // Saturating stall-cycle counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (stall_if && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign valid_q       = idex_q.valid;
    assign alu_src_imm_q = idex_q.alu_src_imm;
    assign reg_write_q   = idex_q.reg_write;
    assign mem_read_q    = idex_q.mem_read;
    assign mem_write_q   = idex_q.mem_write;
    assign illegal_q     = idex_q.illegal;
    assign dest_reg_q    = idex_q.dest_reg;
    assign ext_type_q    = idex_q.ext_type;
    assign imm_q         = idex_q.imm;
    assign stall_cycles  = stall_cnt_q;

endmodule : id_control
`default_nettype wire

// File: tb/tb_id_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_control
//  Description : Self-checking bench for id_control against a behavioural
//                model of the ID stage kept in the bench.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_id_control;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             instr_valid = 1'b0;
    logic [31:0]      instr = 32'h0;
    logic             ex_stall = 1'b0;
    logic             flush = 1'b0;
    logic [1:0]       extension_type;
    logic             stall_if;
    logic             valid_q, alu_src_imm_q, reg_write_q, mem_read_q, mem_write_q;
    logic [4:0]       dest_reg_q;
    logic [1:0]       ext_type_q;
    logic [15:0]      imm_q;
    logic             illegal_q;
    logic [CNT_W-1:0] stall_cycles;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_control #(.CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .ex_stall       (ex_stall),
        .flush          (flush),
        .extension_type (extension_type),
        .stall_if       (stall_if),
        .valid_q        (valid_q),
        .alu_src_imm_q  (alu_src_imm_q),
        .reg_write_q    (reg_write_q),
        .mem_read_q     (mem_read_q),
        .mem_write_q    (mem_write_q),
        .dest_reg_q     (dest_reg_q),
        .ext_type_q     (ext_type_q),
        .imm_q          (imm_q),
        .illegal_q      (illegal_q),
        .stall_cycles   (stall_cycles)
    );

    // Model of the ID/EX slot; all-zero is a bubble
    typedef struct packed {
        bit        valid;
        bit        alu;
        bit        rw;
        bit        mr;
        bit        mw;
        bit        ill;
        bit [4:0]  dest;
        bit [1:0]  ext;
        bit [15:0] imm;
    } slot_t;

    slot_t m_slot = '0;
    int    m_cnt = 0;
    logic  last_stall;

    function automatic logic [31:0] mk_i(input bit [5:0] op, input bit [4:0] rs,
                                         input bit [4:0] rt, input bit [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] mk_r(input bit [4:0] rs, input bit [4:0] rt,
                                         input bit [4:0] rd);
        return {6'h00, rs, rt, rd, 5'h00, 6'h20};
    endfunction

    // Instruction-set table: what an instruction word means for the ID/EX slot
    function automatic void ref_decode(input logic [31:0] w, output slot_t f,
                                       output bit known, output bit reads_rt);
        bit [5:0] op;
        bit       sext, zext, is_lui, is_r, writes;
        op       = w[31:26];
        sext     = op inside {6'h08, 6'h09, 6'h0A, 6'h0B, 6'h23, 6'h2B, 6'h04, 6'h05};
        zext     = op inside {6'h0C, 6'h0D, 6'h0E};
        is_lui   = (op == 6'h0F);
        is_r     = (op == 6'h00);
        known    = sext | zext | is_lui | is_r;
        reads_rt = op inside {6'h00, 6'h2B, 6'h04, 6'h05};
        writes   = is_r | (op inside {[6'h08:6'h0F], 6'h23});
        f        = '0;
        f.valid  = 1'b1;
        f.ext    = is_lui ? 2'b10 : (sext ? 2'b01 : 2'b00);
        f.alu    = op inside {[6'h08:6'h0F], 6'h23, 6'h2B};
        f.rw     = writes;
        f.mr     = (op == 6'h23);
        f.mw     = (op == 6'h2B);
        f.dest   = !writes ? 5'd0 : (is_r ? w[15:11] : w[20:16]);
        f.imm    = w[15:0];
    endfunction

    // One clock: apply inputs, check combinational outputs, then registered ones
    task automatic do_cycle(input string tag, input bit rn, input bit v,
                            input logic [31:0] w, input bit es, input bit fl);
        slot_t f, nxt;
        bit    known, rrt, hz, st;
        int    ncnt;
        rst_n = rn; instr_valid = v; instr = w; ex_stall = es; flush = fl;
        ref_decode(w, f, known, rrt);
        hz = v && m_slot.valid && m_slot.mr && (m_slot.dest != 0) && known &&
             ((w[25:21] == m_slot.dest) || ((w[20:16] == m_slot.dest) && rrt));
        st = rn && !fl && (es || hz);
        #2;
        last_stall = stall_if;
        checks++;
        if (stall_if !== st) begin
            errors++;
            $display("FAIL %s stall_if: got %b want %b", tag, stall_if, st);
        end
        checks++;
        if (extension_type !== (known ? f.ext : 2'b00)) begin
            errors++;
            $display("FAIL %s extension_type: got %b want %b", tag, extension_type,
                     known ? f.ext : 2'b00);
        end
        nxt = m_slot;
        if (!rn || fl)          nxt = '0;
        else if (es)            nxt = m_slot;
        else if (hz || !v)      nxt = '0;
        else if (!known) begin  nxt = '0; nxt.ill = 1'b1; end
        else                    nxt = f;
        if (!rn)                        ncnt = 0;
        else if (st && m_cnt < CNT_MAX) ncnt = m_cnt + 1;
        else                            ncnt = m_cnt;
        @(posedge clk);
        m_slot = nxt;
        m_cnt  = ncnt;
        #1;
        checks++;
        if ({valid_q, alu_src_imm_q, reg_write_q, mem_read_q, mem_write_q, illegal_q,
             dest_reg_q, ext_type_q, imm_q} !== m_slot) begin
            errors++;
            $display("FAIL %s idex: got v%b a%b w%b r%b m%b i%b d%0d e%b imm%h want %p",
                     tag, valid_q, alu_src_imm_q, reg_write_q, mem_read_q, mem_write_q,
                     illegal_q, dest_reg_q, ext_type_q, imm_q, m_slot);
        end
        checks++;
        if (stall_cycles !== CNT_W'(m_cnt)) begin
            errors++;
            $display("FAIL %s stall_cycles: got %0d want %0d", tag, stall_cycles, m_cnt);
        end
    endtask

    task automatic test_reset();
        do_cycle("reset", 1'b0, 1'b1, mk_i(6'h23, 5'd0, 5'd8, 16'h0004), 1'b1, 1'b0);
        checks++;
        if ({valid_q, illegal_q, dest_reg_q, ext_type_q, imm_q, stall_cycles} !== '0) begin
            errors++;
            $display("FAIL reset_state: got v%b i%b d%0d e%b imm%h cnt%0d want all zero",
                     valid_q, illegal_q, dest_reg_q, ext_type_q, imm_q, stall_cycles);
        end
    endtask

    task automatic test_load_use();
        do_cycle("lu_rst", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        do_cycle("lu_lw", 1'b1, 1'b1, mk_i(6'h23, 5'd0, 5'd8, 16'h0010), 1'b0, 1'b0);
        do_cycle("lu_add1", 1'b1, 1'b1, mk_r(5'd8, 5'd10, 5'd9), 1'b0, 1'b0);
        checks++;
        if (last_stall !== 1'b1 || valid_q !== 1'b0) begin
            errors++;
            $display("FAIL lu_bubble: got stall %b valid %b want 1 0", last_stall, valid_q);
        end
        do_cycle("lu_add2", 1'b1, 1'b1, mk_r(5'd8, 5'd10, 5'd9), 1'b0, 1'b0);
        checks++;
        if (last_stall !== 1'b0 || dest_reg_q !== 5'd9 || valid_q !== 1'b1 ||
            stall_cycles !== CNT_W'(1)) begin
            errors++;
            $display("FAIL lu_add: got stall %b dest %0d valid %b cnt %0d want 0 9 1 1",
                     last_stall, dest_reg_q, valid_q, stall_cycles);
        end
    endtask

    task automatic test_lui();
        do_cycle("lui", 1'b1, 1'b1, mk_i(6'h0F, 5'd0, 5'd8, 16'h1234), 1'b0, 1'b0);
        checks++;
        if (ext_type_q !== 2'b10 || imm_q !== 16'h1234 || dest_reg_q !== 5'd8) begin
            errors++;
            $display("FAIL lui_fields: got e%b imm%h d%0d want 10 1234 8",
                     ext_type_q, imm_q, dest_reg_q);
        end
    endtask

    task automatic test_ex_stall();
        logic [28:0] snap;
        do_cycle("es_rst", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        do_cycle("es_addi", 1'b1, 1'b1, mk_i(6'h08, 5'd3, 5'd4, 16'hFFF0), 1'b0, 1'b0);
        snap = {valid_q, alu_src_imm_q, reg_write_q, mem_read_q, mem_write_q, illegal_q,
                dest_reg_q, ext_type_q, imm_q};
        for (int i = 0; i < 3; i++)
            do_cycle("es_hold", 1'b1, 1'b1, mk_i(6'h0D, 5'd1, 5'd7, 16'hBEEF), 1'b1, 1'b0);
        checks++;
        if ({valid_q, alu_src_imm_q, reg_write_q, mem_read_q, mem_write_q, illegal_q,
             dest_reg_q, ext_type_q, imm_q} !== snap || stall_cycles !== CNT_W'(3)) begin
            errors++;
            $display("FAIL es_held: got d%0d imm%h cnt%0d want d4 immfff0 cnt3",
                     dest_reg_q, imm_q, stall_cycles);
        end
        do_cycle("es_ori", 1'b1, 1'b1, mk_i(6'h0D, 5'd1, 5'd7, 16'hBEEF), 1'b0, 1'b0);
        checks++;
        if (dest_reg_q !== 5'd7 || imm_q !== 16'hBEEF || ext_type_q !== 2'b00) begin
            errors++;
            $display("FAIL es_ori: got d%0d imm%h e%b want 7 beef 00",
                     dest_reg_q, imm_q, ext_type_q);
        end
    endtask

    task automatic test_flush_priority();
        do_cycle("fl_lw", 1'b1, 1'b1, mk_i(6'h23, 5'd0, 5'd8, 16'h0000), 1'b0, 1'b0);
        do_cycle("fl_all", 1'b1, 1'b1, mk_r(5'd8, 5'd8, 5'd9), 1'b1, 1'b1);
        checks++;
        if (last_stall !== 1'b0 || valid_q !== 1'b0) begin
            errors++;
            $display("FAIL fl_bubble: got stall %b valid %b want 0 0", last_stall, valid_q);
        end
    endtask

    task automatic test_illegal_zero();
        do_cycle("ill", 1'b1, 1'b1, mk_i(6'h3F, 5'd1, 5'd2, 16'h0), 1'b0, 1'b0);
        checks++;
        if (illegal_q !== 1'b1 || valid_q !== 1'b0 || last_stall !== 1'b0) begin
            errors++;
            $display("FAIL ill_slot: got ill %b valid %b stall %b want 1 0 0",
                     illegal_q, valid_q, last_stall);
        end
        do_cycle("lw_zero", 1'b1, 1'b1, mk_i(6'h23, 5'd3, 5'd0, 16'h8), 1'b0, 1'b0);
        checks++;
        if (illegal_q !== 1'b0) begin
            errors++;
            $display("FAIL ill_one_slot: got ill %b want 0", illegal_q);
        end
        do_cycle("use_zero", 1'b1, 1'b1, mk_r(5'd0, 5'd0, 5'd5), 1'b0, 1'b0);
        checks++;
        if (last_stall !== 1'b0) begin
            errors++;
            $display("FAIL zero_no_stall: got stall %b want 0", last_stall);
        end
    endtask

    task automatic test_reset_mid_stall();
        do_cycle("rm_lw", 1'b1, 1'b1, mk_i(6'h23, 5'd0, 5'd6, 16'h0), 1'b0, 1'b0);
        do_cycle("rm_rst", 1'b0, 1'b1, mk_r(5'd6, 5'd1, 5'd2), 1'b1, 1'b0);
        checks++;
        if (last_stall !== 1'b0 || valid_q !== 1'b0 || stall_cycles !== '0) begin
            errors++;
            $display("FAIL rm_state: got stall %b valid %b cnt %0d want 0 0 0",
                     last_stall, valid_q, stall_cycles);
        end
        do_cycle("rm_after", 1'b1, 1'b1, mk_r(5'd6, 5'd1, 5'd2), 1'b0, 1'b0);
    endtask

    task automatic test_random();
        bit [5:0] ops [15] = '{6'h00, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C,
                               6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h3F, 6'h23};
        logic [31:0] w;
        for (int i = 0; i < 400; i++) begin
            w = {ops[$urandom_range(0, 14)], 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 11'($urandom)};
            do_cycle("rand", ($urandom_range(0, 99) >= 3), ($urandom_range(0, 99) < 85),
                     w, ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 8));
        end
    endtask

    task automatic test_saturation();
        do_cycle("sat_rst", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < (1 << CNT_W) + 5; i++)
            do_cycle("sat", 1'b1, 1'b1, mk_i(6'h0D, 5'd1, 5'd2, 16'h5), 1'b1, 1'b0);
        checks++;
        if (stall_cycles !== {CNT_W{1'b1}}) begin
            errors++;
            $display("FAIL sat_hold: got %0d want %0d", stall_cycles, CNT_MAX);
        end
        do_cycle("sat_clr", 1'b0, 1'b1, mk_i(6'h0D, 5'd1, 5'd2, 16'h5), 1'b1, 1'b0);
        checks++;
        if (stall_cycles !== '0) begin
            errors++;
            $display("FAIL sat_clear: got %0d want 0", stall_cycles);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_lui();
        test_ex_stall();
        test_flush_priority();
        test_illegal_zero();
        test_reset_mid_stall();
        test_random();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_id_control
`default_nettype wire

// File: doc/id_control.md
ID_CONTROL -- requirements
Module: id_control

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the stall-cycle counter.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port instr_valid  input  1  IF/ID holds a real instruction.
REQ-005 SHALL have port instr  input  32  IF/ID instruction word.
REQ-006 SHALL have port ex_stall  input  1  downstream cannot accept; hold ID/EX.
REQ-007 SHALL have port flush  input  1  taken branch; discard ID-stage instruction.
REQ-008 SHALL have port extension_type  output  2  combinational ID-stage drive to immediate extension unit; bit1 = lui, bit0 = signed.
REQ-009 SHALL have port stall_if  output  1  combinational; hold PC and IF/ID.
REQ-010 SHALL have ports valid_q, alu_src_imm_q, reg_write_q, mem_read_q, mem_write_q  output  1 each  registered ID/EX controls.
REQ-011 SHALL have ports dest_reg_q  output  5, ext_type_q  output  2, imm_q  output  16  registered ID/EX fields.
REQ-012 SHALL have port illegal_q  output  1  registered; unknown opcode reached ID/EX slot.
REQ-013 SHALL have port stall_cycles  output  CNT_W  saturating count of stall_if cycles.

Function
REQ-014 Decode SHALL map: addi 0x08, addiu 0x09, slti 0x0A, sltiu 0x0B, lw 0x23, sw 0x2B, beq 0x04, bne 0x05 -> ext 2'b01; andi 0x0C, ori 0x0D, xori 0x0E -> 2'b00; lui 0x0F -> 2'b10; R-type 0x00 -> 2'b00, alu_src_imm 0.
REQ-015 Encoding 2'b11 SHALL never be driven on extension_type or ext_type_q.
REQ-016 dest_reg SHALL be rd for R-type, rt for I-type writers (addi..lui, lw), 0 with reg_write 0 for sw, beq, bne.
REQ-017 Unknown opcode SHALL load a bubble with illegal_q=1 for one slot; no stall.
REQ-018 Bubble SHALL mean valid_q, reg_write_q, mem_read_q, mem_write_q, illegal_q = 0; other fields don't-care but driven 0.
REQ-019 Load-use hazard SHALL be: instr_valid & valid_q & mem_read_q & dest_reg_q!=0 & (rs==dest_reg_q | (rt==dest_reg_q & op in {R-type, sw, beq, bne})).
REQ-020 On hazard (no flush, no ex_stall): stall_if=1, ID/EX loads bubble; next cycle re-decodes same instr with hazard cleared -> exactly one stall cycle per load-use.
REQ-021 On ex_stall=1 (no flush): stall_if=1, all ID/EX registers hold current values.
REQ-022 On flush=1: ID/EX loads bubble, stall_if=0, regardless of ex_stall or hazard.
REQ-023 Priority SHALL be rst_n low > flush > ex_stall > load-use > normal load.
REQ-024 instr_valid=0 (no flush/stall) SHALL load bubble with illegal_q=0.
REQ-025 Normal case SHALL register decoded fields with 1-cycle latency from IF/ID to ID/EX.
REQ-026 stall_cycles SHALL increment each cycle stall_if=1, saturate at all-ones, never wrap.

Reset
REQ-027 rst_n low at an edge SHALL force ID/EX to bubble, ext_type_q=0, imm_q=0, dest_reg_q=0, stall_cycles=0.
REQ-028 stall_if SHALL be 0 while rst_n low; reset mid-stall SHALL abandon the stall with no residual state.

Structure
REQ-029 Opcode constants, extension-type encodings (ZERO 2'b00, SIGN 2'b01, LUI 2'b10) SHALL live in shared package mips_pkg.
REQ-030 Combinational decode SHALL be sub-module id_decode (instr -> control fields); hazard, priority, registers, counter in id_control.

Verification
REQ-031 lw $t0 then add $t1,$t0,$t2 -> stall_if=1 one cycle, one bubble, add in ID/EX next cycle; stall_cycles=1.
REQ-032 lui $t0,0x1234 -> extension_type=2'b10 same cycle; ext_type_q=2'b10, imm_q=0x1234, dest_reg_q=8 after one edge.
REQ-033 ori in ID with ex_stall=1 for 3 cycles -> ID/EX unchanged 3 cycles, stall_cycles=3, ori loads on 4th edge.
REQ-034 flush=1 together with load-use hazard and ex_stall -> bubble, stall_if=0.
REQ-035 opcode 0x3F -> illegal_q=1 one cycle, valid_q=0; lw $zero then use of $zero -> no stall.
REQ-036 Force 2^CNT_W+5 stall cycles -> stall_cycles holds all-ones; rst_n low one edge -> 0.
